// File: rtl/phys_free_list_if.sv
// Rename/commit-facing signal bundle for the physical tag free list.
// The allocator sits on the slave side, and the rename and commit stages drive the master side.
interface phys_free_list_if #(
    parameter int CELLS           = 128,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
    parameter int CNT_WIDTH       = $clog2(CELLS + 1)
);
    logic [ALLOC_PORTS-1:0]                 alloc_req;
    logic                                   alloc_ok;
    logic [ALLOC_PORTS*PHYS_ADDR_WIDTH-1:0] alloc_addr;
    logic [FREE_PORTS-1:0]                  free_en;
    logic [FREE_PORTS*PHYS_ADDR_WIDTH-1:0]  free_addr;
    logic [CNT_WIDTH-1:0]                   free_count;
    logic                                   ready;
    logic                                   overflow_err;

    modport master (
        output alloc_req, free_en, free_addr,
        input  alloc_ok, alloc_addr, free_count, ready, overflow_err
    );

    modport slave (
        input  alloc_req, free_en, free_addr,
        output alloc_ok, alloc_addr, free_count, ready, overflow_err
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags: seeds non-architectural tags after reset,
// grants up to ALLOC_PORTS tags per cycle (all-or-nothing) and takes back up to FREE_PORTS.
module phys_free_list #(
    parameter int CELLS           = 128,
    parameter int ARCH_REGS       = 32,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
    parameter int CNT_WIDTH       = $clog2(CELLS + 1)
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             clk_en,
    phys_free_list_if.slave  bus
);
    localparam int LANE_MAX = (ALLOC_PORTS > FREE_PORTS) ? ALLOC_PORTS : FREE_PORTS;
    localparam int LANE_W   = $clog2(LANE_MAX + 1);
    localparam int W        = PHYS_ADDR_WIDTH;
    localparam logic [W-1:0]         INIT_LAST = W'(CELLS - ARCH_REGS - 1);
    localparam logic [W-1:0]         ARCH_BASE = W'(ARCH_REGS);
    localparam logic [W-1:0]         PTR_ONE   = W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   CELLS_EXT = (CNT_WIDTH + 1)'(CELLS);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [W-1:0]           fifo_r [CELLS];
    logic [W-1:0]           head_r;
    logic [W-1:0]           tail_r;
    logic [W-1:0]           init_idx_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   overflow_r;

    logic [LANE_W-1:0]      req_pos_s  [ALLOC_PORTS];
    logic [LANE_W-1:0]      free_pos_s [FREE_PORTS];
    logic [LANE_W-1:0]      n_req_s;
    logic [LANE_W-1:0]      n_free_s;
    logic                   is_ready_s;
    logic                   alloc_ok_s;
    logic [CNT_WIDTH-1:0]   grant_n_s;
    logic [CNT_WIDTH-1:0]   after_alloc_s;
    logic [CNT_WIDTH:0]     total_s;
    logic                   free_acc_s;
    logic                   free_drop_s;
    logic [W-1:0]           rd_idx_s   [ALLOC_PORTS];

    // Per-lane slot offsets: each active lane takes the next consecutive FIFO slot.
    always_comb begin
        n_req_s  = '0;
        n_free_s = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            req_pos_s[i] = n_req_s;
            n_req_s      = n_req_s + LANE_W'(bus.alloc_req[i]);
        end
        for (int j = 0; j < FREE_PORTS; j++) begin
            free_pos_s[j] = n_free_s;
            n_free_s      = n_free_s + LANE_W'(bus.free_en[j]);
        end
    end

    // Grant decision, occupancy check for the release set, and read-out of granted tags.
    always_comb begin
        is_ready_s    = (state_r == ST_READY);
        alloc_ok_s    = is_ready_s && (n_req_s != '0) && (count_r >= CNT_WIDTH'(n_req_s));
        grant_n_s     = alloc_ok_s ? CNT_WIDTH'(n_req_s) : '0;
        after_alloc_s = count_r - grant_n_s;
        total_s       = {1'b0, after_alloc_s} + (CNT_WIDTH + 1)'(n_free_s);
        free_acc_s    = is_ready_s && (n_free_s != '0) && (total_s <= CELLS_EXT);
        free_drop_s   = is_ready_s && (n_free_s != '0) && (total_s > CELLS_EXT);
        bus.alloc_addr = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            rd_idx_s[i] = head_r + W'(req_pos_s[i]);
            if (alloc_ok_s && bus.alloc_req[i]) begin
                bus.alloc_addr[i*W +: W] = fifo_r[rd_idx_s[i]];
            end else begin
                bus.alloc_addr[i*W +: W] = '0;
            end
        end
    end

    // Next-state logic: INIT ends after the last non-architectural tag has been seeded.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_idx_r == INIT_LAST) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: state_nxt_s = ST_READY;
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // State, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_r    <= ST_INIT;
            head_r     <= '0;
            tail_r     <= '0;
            init_idx_r <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (clk_en) begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                tail_r     <= tail_r + PTR_ONE;
                init_idx_r <= init_idx_r + PTR_ONE;
                count_r    <= count_r + CNT_ONE;
            end else begin
                if (alloc_ok_s) begin
                    head_r <= head_r + W'(n_req_s);
                end
                if (free_acc_s) begin
                    tail_r <= tail_r + W'(n_free_s);
                end
                // A rejected release set still lets the grant go through.
                count_r <= after_alloc_s + (free_acc_s ? CNT_WIDTH'(n_free_s) : '0);
                if (free_drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // FIFO storage: seeded with ARCH_REGS.. during INIT, then refilled by released tags.
    always_ff @(posedge clk) begin
        if (!sync_rst && clk_en) begin
            if (state_r == ST_INIT) begin
                fifo_r[tail_r] <= ARCH_BASE + init_idx_r;
            end else if (free_acc_s) begin
                for (int j = 0; j < FREE_PORTS; j++) begin
                    if (bus.free_en[j]) begin
                        fifo_r[tail_r + W'(free_pos_s[j])] <= bus.free_addr[j*W +: W];
                    end
                end
            end
        end
    end

    assign bus.alloc_ok     = alloc_ok_s;
    assign bus.free_count   = count_r;
    assign bus.ready        = (state_r == ST_READY);
    assign bus.overflow_err = overflow_r;
endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: grant expectations are queued at issue time
// and a negedge monitor pops them whenever a request is presented while ready.
module tb_phys_free_list;
    localparam int W = 7;

    typedef struct packed {
        logic        ok;
        logic [27:0] addr;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic sync_rst;
    logic clk_en;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_good;

    phys_free_list_if bus ();

    phys_free_list dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle of stimulus; a grant expectation is queued whenever a request is made.
    task automatic issue(input logic [3:0] req, input logic [3:0] fen, input logic [27:0] fa,
                         input logic en, input logic ok, input logic [27:0] ea, input int ecnt);
        exp_t e;
        bus.alloc_req = req;
        bus.free_en   = fen;
        bus.free_addr = fa;
        clk_en        = en;
        if (req != 4'b0000) begin
            e.ok   = ok;
            e.addr = ea;
            e.cnt  = 8'(ecnt);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.alloc_req = 4'b0000;
        bus.free_en   = 4'b0000;
        bus.free_addr = 28'd0;
        clk_en        = 1'b1;
    endtask

    // Scoreboard monitor: compares grant, requested-lane tags and occupancy.
    always @(negedge clk) begin
        if (bus.ready && (bus.alloc_req != 4'b0000)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: request %b with no queued expectation", bus.alloc_req);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_good = (bus.alloc_ok == mon_e.ok) && (bus.free_count == mon_e.cnt);
                for (int i = 0; i < 4; i++) begin
                    if (mon_e.ok && bus.alloc_req[i] &&
                        (bus.alloc_addr[i*W +: W] != mon_e.addr[i*W +: W])) begin
                        mon_good = 1'b0;
                    end
                end
                if (!mon_good) begin
                    bad++;
                    $display("FAIL sb_grant: req=%b got ok=%0b addr=%h cnt=%0d expected ok=%0b addr=%h cnt=%0d",
                             bus.alloc_req, bus.alloc_ok, bus.alloc_addr, bus.free_count,
                             mon_e.ok, mon_e.addr, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        int n_en;
        int cyc;
        bus.alloc_req = 4'b1111;
        bus.free_en   = 4'b0000;
        bus.free_addr = 28'd0;
        clk_en        = 1'b1;
        sync_rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_count", int'(bus.free_count), 0);
        chk("rst_ok", int'(bus.alloc_ok), 0);
        chk("rst_ovf", int'(bus.overflow_err), 0);
        chk("rst_addr", int'(bus.alloc_addr), 0);

        // INIT with gated cycles and requests held high
        sync_rst = 1'b0;
        n_en = 0;
        cyc  = 0;
        while (!bus.ready && cyc < 400) begin
            clk_en = ((cyc % 7) != 3);
            @(posedge clk);
            if (clk_en) n_en++;
            #1;
            if (cyc == 10) chk("init_no_grant", int'(bus.alloc_ok), 0);
            cyc++;
        end
        clk_en = 1'b1;
        bus.alloc_req = 4'b0000;
        chk("init_len", n_en, 96);
        chk("init_count", int'(bus.free_count), 96);

        // Test 1 and 2: full and sparse requests
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(32, 33, 34, 35), 96);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(36, 37, 38, 39), 92);
        issue(4'b1010, 4'b0000, 28'd0, 1'b1, 1'b1, pk(0, 40, 0, 41), 88);
        issue(4'b0001, 4'b0000, 28'd0, 1'b1, 1'b1, pk(42, 0, 0, 0), 86);

        // Test 3: drain to 2 then stall
        for (int k = 0; k < 20; k++)
            issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1,
                  pk(43 + 4*k, 44 + 4*k, 45 + 4*k, 46 + 4*k), 85 - 4*k);
        issue(4'b0111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(123, 124, 125, 0), 5);
        issue(4'b0111, 4'b0000, 28'd0, 1'b1, 1'b0, 28'd0, 2);
        issue(4'b0011, 4'b0000, 28'd0, 1'b1, 1'b1, pk(126, 127, 0, 0), 2);
        issue(4'b0001, 4'b0000, 28'd0, 1'b1, 1'b0, 28'd0, 0);

        // Test 4: tail crosses 127->0
        for (int k = 0; k < 7; k++)
            issue(4'b0000, 4'b1111, pk(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b0000, 4'b0101, pk(60, 0, 61, 0), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b0000, 4'b1111, pk(100, 101, 102, 103), 1'b1, 1'b0, 28'd0, 0);
        chk("wrap_count", int'(bus.free_count), 34);
        for (int k = 0; k < 7; k++)
            issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1,
                  pk(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k), 34 - 4*k);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(60, 61, 100, 101), 6);
        issue(4'b0011, 4'b0000, 28'd0, 1'b1, 1'b1, pk(102, 103, 0, 0), 2);
        chk("wrap_empty", int'(bus.free_count), 0);

        // Test 5: simultaneous alloc and free
        issue(4'b0000, 4'b1111, pk(10, 11, 12, 13), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b0000, 4'b1111, pk(14, 15, 16, 17), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b1111, 4'b1111, pk(20, 21, 22, 23), 1'b1, 1'b1, pk(10, 11, 12, 13), 8);
        chk("simul_count", int'(bus.free_count), 8);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(14, 15, 16, 17), 8);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(20, 21, 22, 23), 4);
        chk("simul_drain", int'(bus.free_count), 0);

        // A tag freed this cycle is not grantable until the next
        issue(4'b0001, 4'b0001, pk(30, 0, 0, 0), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b0001, 4'b0000, 28'd0, 1'b1, 1'b1, pk(30, 0, 0, 0), 1);

        // clk_en low: grant shown but not consumed
        issue(4'b0000, 4'b1111, pk(40, 41, 42, 43), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b1111, 4'b0000, 28'd0, 1'b0, 1'b1, pk(40, 41, 42, 43), 4);
        chk("hold_count", int'(bus.free_count), 4);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(40, 41, 42, 43), 4);
        chk("hold_consumed", int'(bus.free_count), 0);

        // Test 6: overflow
        for (int k = 0; k < 31; k++)
            issue(4'b0000, 4'b1111, pk(4*k, 4*k + 1, 4*k + 2, 4*k + 3), 1'b1, 1'b0, 28'd0, 0);
        issue(4'b0000, 4'b0111, pk(124, 125, 126, 0), 1'b1, 1'b0, 28'd0, 0);
        chk("fill_count", int'(bus.free_count), 127);
        chk("fill_ovf", int'(bus.overflow_err), 0);
        issue(4'b0000, 4'b0011, pk(1, 2, 0, 0), 1'b1, 1'b0, 28'd0, 0);
        chk("ovf_set", int'(bus.overflow_err), 1);
        chk("ovf_dropped", int'(bus.free_count), 127);
        issue(4'b0001, 4'b1111, pk(120, 121, 122, 123), 1'b1, 1'b1, pk(0, 0, 0, 0), 127);
        chk("ovf_alloc_kept", int'(bus.free_count), 126);
        issue(4'b0000, 4'b0011, pk(124, 125, 0, 0), 1'b1, 1'b0, 28'd0, 0);
        chk("full_count", int'(bus.free_count), 128);
        chk("ovf_sticky", int'(bus.overflow_err), 1);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(1, 2, 3, 4), 128);
        chk("after_full", int'(bus.free_count), 124);

        // Reset, then reset again mid-INIT at cycle 50
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        chk("rst2_ovf", int'(bus.overflow_err), 0);
        chk("rst2_count", int'(bus.free_count), 0);
        repeat (50) @(posedge clk);
        #1;
        chk("mid_init_ready", int'(bus.ready), 0);
        chk("mid_init_count", int'(bus.free_count), 50);
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        chk("rst3_ready", int'(bus.ready), 0);
        chk("rst3_count", int'(bus.free_count), 0);
        n_en = 0;
        while (!bus.ready && n_en < 400) begin
            @(posedge clk);
            n_en++;
            #1;
        end
        chk("reinit_len", n_en, 96);
        issue(4'b1111, 4'b0000, 28'd0, 1'b1, 1'b1, pk(32, 33, 34, 35), 96);

        chk("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
